// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache set controller.
package cache_pkg;

   localparam int unsigned NUM_WAYS_DEF = 4;
   localparam int unsigned TAG_BITS_DEF = 51;

   typedef logic [$clog2(NUM_WAYS_DEF)-1:0] way_idx_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOOKUP = 3'd1,
      WB     = 3'd2,
      FILL   = 3'd3,
      RESP   = 3'd4
   } ctrl_state_e;

endpackage

// File: rtl/cache_victim_sel.sv
// Victim picker: lowest invalid way, otherwise the round-robin pointer.
module cache_victim_sel #(
   parameter int unsigned NUM_WAYS = 4,
   localparam int unsigned WAY_W   = $clog2(NUM_WAYS)
) (
   input  logic [NUM_WAYS-1:0] i_way_val,
   input  logic [WAY_W-1:0]    i_ptr,
   output logic [WAY_W-1:0]    o_victim_c
);

   logic w_found;

   always_comb begin
      o_victim_c = i_ptr;
      w_found    = 1'b0;
      for (int unsigned i = 0; i < NUM_WAYS; i++) begin
         if (!i_way_val[i] && !w_found) begin
            o_victim_c = WAY_W'(i);
            w_found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cache_set_ctrl.sv
// Sequencing controller for one cache set: lookup, victim select, writeback, fill, respond.
// Optional CACHE_SET_CTRL_PERF_EN adds saturating hit/miss/writeback counters.
module cache_set_ctrl
   import cache_pkg::*;
#(
   parameter int unsigned NUM_WAYS = NUM_WAYS_DEF,
   parameter int unsigned TAG_BITS = TAG_BITS_DEF,
   localparam int unsigned WAY_W   = $clog2(NUM_WAYS)
) (
   input  logic                         clk_i,
   input  logic                         srst_i,
   input  logic                         req_valid_i,
   output logic                         req_ready_o,
   input  logic                         req_write_i,
   input  logic [TAG_BITS-1:0]          req_tag_i,
   input  logic [NUM_WAYS*TAG_BITS-1:0] way_tag_i,
   input  logic [NUM_WAYS-1:0]          way_val_i,
   input  logic [NUM_WAYS-1:0]          way_dirty_i,
   output logic [NUM_WAYS-1:0]          tag_en_o,
   output logic [NUM_WAYS-1:0]          val_en_o,
   output logic                         val_o,
   output logic [NUM_WAYS-1:0]          dirty_en_o,
   output logic                         dirty_o,
   output logic [NUM_WAYS-1:0]          evp_en_o,
   output logic                         evp_o,
   output logic [NUM_WAYS-1:0]          data_en_o,
   output logic                         wb_valid_o,
   input  logic                         wb_ready_i,
   output logic [WAY_W-1:0]             wb_way_o,
   output logic [TAG_BITS-1:0]          wb_tag_o,
   output logic                         fill_valid_o,
   input  logic                         fill_ready_i,
   input  logic                         fill_done_i,
   output logic                         rsp_valid_o,
   input  logic                         rsp_ready_i,
   output logic                         rsp_hit_o,
   output logic [WAY_W-1:0]             rsp_way_o
`ifdef CACHE_SET_CTRL_PERF_EN
   ,
   output logic [31:0]                  hit_cnt_o,
   output logic [31:0]                  miss_cnt_o,
   output logic [31:0]                  wb_cnt_o
`endif
);

   ctrl_state_e         r_state, w_state_nxt;
   logic                r_write;
   logic [TAG_BITS-1:0] r_tag;
   logic [WAY_W-1:0]    r_way;
   logic                r_hit;
   logic [TAG_BITS-1:0] r_wb_tag;
   logic [WAY_W-1:0]    r_ptr;
   logic                r_fill_acked, w_fill_acked_nxt;
   logic                r_req_ready, r_wb_valid, r_fill_valid, r_rsp_valid;

   logic [TAG_BITS-1:0] w_way_tag [NUM_WAYS];
   logic [NUM_WAYS-1:0] w_hit_vec;
   logic                w_hit;
   logic [WAY_W-1:0]    w_hit_idx;
   logic [WAY_W-1:0]    w_vict;
   logic                w_vict_dirty;
   logic [NUM_WAYS-1:0] w_hit_oh, w_vict_oh, w_way_oh;
   logic                w_fill_fire;

   // Tag compare against every way; lowest matching index wins.
   always_comb begin
      w_hit_idx = '0;
      w_hit     = 1'b0;
      for (int unsigned i = 0; i < NUM_WAYS; i++) begin
         w_way_tag[i] = way_tag_i[i*TAG_BITS +: TAG_BITS];
         w_hit_vec[i] = way_val_i[i] && (w_way_tag[i] == r_tag);
         if (w_hit_vec[i] && !w_hit) begin
            w_hit_idx = WAY_W'(i);
            w_hit     = 1'b1;
         end
      end
   end

   cache_victim_sel #(.NUM_WAYS(NUM_WAYS)) u_victim_sel (
      .i_way_val  (way_val_i),
      .i_ptr      (r_ptr),
      .o_victim_c (w_vict)
   );

   assign w_vict_dirty = way_val_i[w_vict] & way_dirty_i[w_vict];
   assign w_hit_oh     = NUM_WAYS'(1) << w_hit_idx;
   assign w_vict_oh    = NUM_WAYS'(1) << w_vict;
   assign w_way_oh     = NUM_WAYS'(1) << r_way;
   assign w_fill_fire  = (r_state == FILL) && r_fill_acked && fill_done_i;

   // Next state and line-register write strobes (strobes coincide with the triggering cycle).
   always_comb begin
      w_state_nxt      = r_state;
      w_fill_acked_nxt = r_fill_acked;
      tag_en_o         = '0;
      val_en_o         = '0;
      val_o            = 1'b0;
      dirty_en_o       = '0;
      dirty_o          = 1'b0;
      evp_en_o         = '0;
      evp_o            = 1'b0;
      data_en_o        = '0;
      unique case (r_state)
         IDLE: begin
            if (req_valid_i) w_state_nxt = LOOKUP;
         end
         LOOKUP: begin
            if (w_hit) begin
               w_state_nxt = RESP;
               if (r_write) begin
                  dirty_en_o = w_hit_oh;
                  dirty_o    = 1'b1;
               end
            end else begin
               evp_en_o         = w_vict_oh;
               evp_o            = 1'b1;
               val_en_o         = w_vict_oh;
               val_o            = 1'b0;
               w_fill_acked_nxt = 1'b0;
               w_state_nxt      = w_vict_dirty ? WB : FILL;
            end
         end
         WB: begin
            if (wb_ready_i) begin
               w_state_nxt      = FILL;
               w_fill_acked_nxt = 1'b0;
            end
         end
         FILL: begin
            if (!r_fill_acked) begin
               if (fill_ready_i) w_fill_acked_nxt = 1'b1;
            end else if (fill_done_i) begin
               data_en_o   = w_way_oh;
               tag_en_o    = w_way_oh;
               val_en_o    = w_way_oh;
               val_o       = 1'b1;
               dirty_en_o  = w_way_oh;
               dirty_o     = r_write;
               evp_en_o    = w_way_oh;
               evp_o       = 1'b0;
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready_i) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_state      <= IDLE;
         r_write      <= 1'b0;
         r_tag        <= '0;
         r_way        <= '0;
         r_hit        <= 1'b0;
         r_wb_tag     <= '0;
         r_ptr        <= '0;
         r_fill_acked <= 1'b0;
         r_req_ready  <= 1'b1;
         r_wb_valid   <= 1'b0;
         r_fill_valid <= 1'b0;
         r_rsp_valid  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_fill_acked <= w_fill_acked_nxt;
         r_req_ready  <= (w_state_nxt == IDLE);
         r_wb_valid   <= (w_state_nxt == WB);
         r_fill_valid <= (w_state_nxt == FILL) && !w_fill_acked_nxt;
         r_rsp_valid  <= (w_state_nxt == RESP);
         if ((r_state == IDLE) && req_valid_i) begin
            r_write <= req_write_i;
            r_tag   <= req_tag_i;
         end
         if (r_state == LOOKUP) begin
            r_hit    <= w_hit;
            r_way    <= w_hit ? w_hit_idx : w_vict;
            r_wb_tag <= w_way_tag[w_vict];
         end
         if (w_fill_fire) r_ptr <= WAY_W'(r_ptr + 1'b1);
      end
   end

   assign req_ready_o  = r_req_ready;
   assign wb_valid_o   = r_wb_valid;
   assign wb_way_o     = r_way;
   assign wb_tag_o     = r_wb_tag;
   assign fill_valid_o = r_fill_valid;
   assign rsp_valid_o  = r_rsp_valid;
   assign rsp_hit_o    = r_hit;
   assign rsp_way_o    = r_way;

`ifdef CACHE_SET_CTRL_PERF_EN
   // Saturating event counters.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
         wb_cnt_o   <= '0;
      end else begin
         if ((r_state == LOOKUP) && w_hit && (hit_cnt_o != '1))
            hit_cnt_o <= hit_cnt_o + 32'd1;
         if ((r_state == LOOKUP) && !w_hit && (miss_cnt_o != '1))
            miss_cnt_o <= miss_cnt_o + 32'd1;
         if ((r_state == WB) && wb_ready_i && (wb_cnt_o != '1))
            wb_cnt_o <= wb_cnt_o + 32'd1;
      end
   end
`endif

   // Multiple matching valid ways indicate corrupted line state.
   a_single_hit : assert property (@(posedge clk_i) disable iff (srst_i)
      (r_state == LOOKUP) |-> $onehot0(w_hit_vec));

endmodule
